// File: rtl/pbus_arbiter_if.sv
// PBus bundle between the two masters (CPU = M0, COP = M1), the arbiter and the target port.
// The arbiter uses the slave modport; the masters/target side uses the master modport.
interface pbus_arbiter_if;
  logic [1:0]  m0_req;
  logic [14:0] m0_addr;
  logic [1:0]  m0_be;
  logic        m0_aspace;
  logic [15:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rdy;

  logic [1:0]  m1_req;
  logic [14:0] m1_addr;
  logic [1:0]  m1_be;
  logic        m1_aspace;
  logic [15:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rdy;

  logic [15:0] m_rdata;

  logic [1:0]  t_req;
  logic [14:0] t_addr;
  logic [1:0]  t_be;
  logic        t_aspace;
  logic [15:0] t_wdata;
  logic        t_rdy;
  logic [15:0] t_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_be, m0_aspace, m0_wdata,
    input  m1_req, m1_addr, m1_be, m1_aspace, m1_wdata,
    output m0_gnt, m0_rdy, m1_gnt, m1_rdy, m_rdata,
    output t_req, t_addr, t_be, t_aspace, t_wdata,
    input  t_rdy, t_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_be, m0_aspace, m0_wdata,
    output m1_req, m1_addr, m1_be, m1_aspace, m1_wdata,
    input  m0_gnt, m0_rdy, m1_gnt, m1_rdy, m_rdata,
    input  t_req, t_addr, t_be, t_aspace, t_wdata,
    output t_rdy, t_rdata
  );
endinterface

// File: rtl/pbus_arbiter.sv
// Two-master PBus arbiter: one transaction at a time, IDLE->GRANT->BUSY->RELEASE,
// with a per-transaction timeout so a dead target always completes with ERR_DATA.
module pbus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8,
  parameter logic [15:0] ERR_DATA    = 16'hDEAD,
  parameter bit          FAIR        = 1'b1
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           cop_prio,
  input  logic           err_clr,
  pbus_arbiter_if.slave  bus,
  output logic           owner,
  output logic           busy,
  output logic           err,
  output logic           err_master
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state;
  state_t          state_nxt;
  logic            owner_nxt;
  logic            rr_ptr;
  logic [TO_W-1:0] cnt;
  logic            gnt0;
  logic            gnt1;
  logic            done;
  logic            done_to;

  logic [1:0]      own_req;
  logic [14:0]     own_addr;
  logic [1:0]      own_be;
  logic            own_aspace;
  logic [15:0]     own_wdata;

  logic [1:0]      t_req_c;
  logic [14:0]     t_addr_c;
  logic [1:0]      t_be_c;
  logic            t_aspace_c;
  logic [15:0]     t_wdata_c;
  logic [15:0]     rdata_c;

  // cop_prio beats fairness; otherwise the master not served last wins, or COP when not fair.
  function automatic logic pick_winner(input logic v0, input logic v1,
                                       input logic prio, input logic last);
    logic win;
    if (v0 && v1) begin
      if (prio)      win = 1'b1;
      else if (FAIR) win = ~last;
      else           win = 1'b1;
    end else begin
      win = v1;
    end
    return win;
  endfunction

  always_comb begin
    own_req    = owner ? bus.m1_req    : bus.m0_req;
    own_addr   = owner ? bus.m1_addr   : bus.m0_addr;
    own_be     = owner ? bus.m1_be     : bus.m0_be;
    own_aspace = owner ? bus.m1_aspace : bus.m0_aspace;
    own_wdata  = owner ? bus.m1_wdata  : bus.m0_wdata;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      cnt        <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      err        <= 1'b0;
      err_master <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      // Counter only runs in BUSY and restarts from zero on every entry, so it cannot wrap.
      cnt    <= (state == BUSY) ? cnt + 1'b1 : '0;
      gnt0   <= ((state_nxt == GRANT) || (state_nxt == BUSY)) && !owner_nxt;
      gnt1   <= ((state_nxt == GRANT) || (state_nxt == BUSY)) &&  owner_nxt;
      if (state == RELEASE) rr_ptr <= owner;
      if (done_to) begin
        err        <= 1'b1;
        err_master <= owner;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    done       = 1'b0;
    done_to    = 1'b0;
    rdata_c    = 16'h0000;
    t_req_c    = 2'b00;
    t_addr_c   = 15'h0000;
    t_be_c     = 2'b00;
    t_aspace_c = 1'b0;
    t_wdata_c  = 16'h0000;
    case (state)
      IDLE: begin
        if (bus.m0_req[0] || bus.m1_req[0]) begin
          owner_nxt = pick_winner(bus.m0_req[0], bus.m1_req[0], cop_prio, rr_ptr);
          state_nxt = GRANT;
        end
      end
      GRANT: state_nxt = BUSY;
      BUSY: begin
        t_req_c    = own_req;
        t_addr_c   = own_addr;
        t_be_c     = own_be;
        t_aspace_c = own_aspace;
        t_wdata_c  = own_wdata;
        // A withdrawn request aborts silently, even if the target answers in the same cycle.
        if (!own_req[0]) begin
          state_nxt = RELEASE;
        end else if (bus.t_rdy) begin
          done      = 1'b1;
          rdata_c   = bus.t_rdata;
          state_nxt = RELEASE;
        end else if (cnt == TO_LAST) begin
          done      = 1'b1;
          done_to   = 1'b1;
          rdata_c   = ERR_DATA;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.m0_gnt   = gnt0;
  assign bus.m1_gnt   = gnt1;
  assign bus.m0_rdy   = done && !owner;
  assign bus.m1_rdy   = done &&  owner;
  assign bus.m_rdata  = rdata_c;
  assign bus.t_req    = t_req_c;
  assign bus.t_addr   = t_addr_c;
  assign bus.t_be     = t_be_c;
  assign bus.t_aspace = t_aspace_c;
  assign bus.t_wdata  = t_wdata_c;
  assign busy         = (state != IDLE);

endmodule
